// File: rtl/mips32_pkg.sv
// Shared encodings and default widths for the memory arbiter and its helpers.
package mips32_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter tracking how long a fetch request has been denied.
module arb_age_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic       hold,
  output logic [3:0] count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  // hold dominates so a halted core keeps its accumulated age
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store traffic.
// Handshake: a requester holds req/addr/we/wdata until it sees gnt high in a cycle; the transfer is accepted at that clock edge.
module mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  arb_state_t state, state_nxt;
  owner_t     owner;
  logic       owner_vld;
  logic [2:0] lat_cnt;
  logic [3:0] wait_cnt;
  logic       fetch_ok;
  logic       fetch_pri;
  logic       rd_grant;
  logic       rd_done;

  assign fetch_ok  = if_req && !halt;
  assign fetch_pri = fetch_ok && (wait_cnt == MAX_CNT);
  assign rd_grant  = if_gnt || (d_gnt && !d_we);
  assign rd_done   = (state == BUSY) && (lat_cnt == LAT_CNT);

  arb_age_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (fetch_ok && !if_gnt),
    .clr  (if_gnt || !if_req),
    .hold (halt),
    .count(wait_cnt)
  );

  // Grants are gated by rst_n so every output is low while reset is held
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (fetch_pri) begin
            if_gnt = 1'b1;
          end else if (d_req) begin
            d_gnt = 1'b1;
          end else if (fetch_ok) begin
            if_gnt = 1'b1;
          end
          if (if_gnt || (d_gnt && !d_we)) begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (rd_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner     <= OWN_IF;
      owner_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_grant) begin
        lat_cnt   <= 3'd1;
        owner     <= if_gnt ? OWN_IF : OWN_D;
        owner_vld <= 1'b1;
      end else if (rd_done) begin
        lat_cnt   <= '0;
        owner_vld <= 1'b0;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end

  // Memory side is forced to zero whenever no access is strobed
  always_comb begin
    m_en    = if_gnt || d_gnt;
    m_we    = d_gnt && d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (if_gnt) begin
      m_addr = if_addr;
    end else if (d_gnt) begin
      m_addr = d_addr;
      if (d_we) begin
        m_wdata = d_wdata;
      end
    end
  end

  assign if_rvalid = rd_done && owner_vld && (owner == OWN_IF);
  assign d_rvalid  = rd_done && owner_vld && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? m_rdata : '0;
  assign d_rdata   = d_rvalid ? m_rdata : '0;
  assign busy      = (state == BUSY);

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(if_gnt && d_gnt));
  a_no_gnt_busy: assert property (@(posedge clk) disable iff (!rst_n) busy |-> !m_en);

endmodule
